// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - operation encoding and chunk-width helper for the pipelined adder
package pipelined_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Width of one carry-chained chunk; falls back to the full width on a
    // degenerate stage count so elaboration reaches the configuration check.
    function automatic int chunk_w(input int n, input int stages);
        return (stages > 0) ? (n / stages) : n;
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// rtl/pipelined_adder_stage.sv - one W-bit chunk adder with registered sum, carry and valid bit
module pipelined_adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_load,
    input  logic         i_valid,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic         o_valid,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic         r_valid;
    logic [W-1:0] r_sum;
    logic         r_cout;
    logic [W:0]   w_add;

    assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

    // Capture the chunk result when the stage is free to advance; flush only drops the valid bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= i_valid;
            end
            if (i_load) begin
                r_sum  <= w_add[W-1:0];
                r_cout <= w_add[W];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_sum   = r_sum;
    assign o_cout  = r_cout;

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - chunked pipelined add/subtract with valid/ready; PIPELINED_ADDER_SAT_EN enables signed saturation
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int N      = 20,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  op_t          op,
    input  logic         carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         carry_out,
    output logic         overflow,
    output logic         zero
);

    localparam int W = chunk_w(N, STAGES);

    if (STAGES < 1 || (N % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: N must be a multiple of STAGES and STAGES >= 1");
    end

    logic [N-1:0]              w_b_eff;
    logic                      w_cin_eff;
    logic [STAGES:0]           w_rdy;
    logic [STAGES-1:0]         w_v;
    logic [STAGES-1:0]         w_vin;
    logic [STAGES-1:0]         w_cin;
    logic [STAGES-1:0]         w_cout;
    logic [STAGES-1:0][W-1:0]  w_a_in;
    logic [STAGES-1:0][W-1:0]  w_b_in;
    logic [STAGES-1:0][W-1:0]  w_sum;
    logic [STAGES-1:0][W-1:0]  w_s_raw;
    logic [N-1:0]              w_s_flat;
    logic [N-1:0]              w_s_fin;
    logic                      w_ovf;
    logic                      r_a_msb;
    logic                      r_b_msb;

    // Subtraction is a + ~b + 1; the carry-in doubles as an inverted borrow-in.
    assign w_b_eff   = (op == OP_SUB) ? ~b : b;
    assign w_cin_eff = carry_in ^ (op == OP_SUB);

    // Backward ready chain: a stage may take new data if it is empty or its successor moves.
    always_comb begin
        w_rdy         = '0;
        w_rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_rdy[k] = ~w_v[k] | w_rdy[k + 1];
        end
    end

    assign in_ready  = w_rdy[0] & ~flush;
    assign w_a_in[0] = a[W-1:0];
    assign w_b_in[0] = w_b_eff[W-1:0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_cin[k] = w_cin_eff;
            assign w_vin[k] = in_valid & ~flush;
        end else begin : g_next
            assign w_cin[k] = w_cout[k-1];
            assign w_vin[k] = w_v[k-1];
        end

        pipelined_adder_stage #(
            .W (W)
        ) u_stage (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_flush (flush),
            .i_load  (w_rdy[k]),
            .i_valid (w_vin[k]),
            .i_a     (w_a_in[k]),
            .i_b     (w_b_in[k]),
            .i_cin   (w_cin[k]),
            .o_valid (w_v[k]),
            .o_sum   (w_sum[k]),
            .o_cout  (w_cout[k])
        );
    end

    // Operand chunk j waits j stages so it meets the carry rippling up from chunk j-1.
    for (genvar j = 1; j < STAGES; j++) begin : g_skew
        logic [W-1:0] r_a_q [0:j-1];
        logic [W-1:0] r_b_q [0:j-1];

        // Delay line for operand chunk j; slot d advances with stage d.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int d = 0; d < j; d++) begin
                    r_a_q[d] <= '0;
                    r_b_q[d] <= '0;
                end
            end else begin
                if (w_rdy[0]) begin
                    r_a_q[0] <= a[j*W +: W];
                    r_b_q[0] <= w_b_eff[j*W +: W];
                end
                for (int d = 1; d < j; d++) begin
                    if (w_rdy[d]) begin
                        r_a_q[d] <= r_a_q[d-1];
                        r_b_q[d] <= r_b_q[d-1];
                    end
                end
            end
        end

        assign w_a_in[j] = r_a_q[j-1];
        assign w_b_in[j] = r_b_q[j-1];
    end

    // Result chunk j finished early and rides alongside its op until the last stage.
    for (genvar j = 0; j < STAGES; j++) begin : g_deskew
        if (j == STAGES - 1) begin : g_top
            assign w_s_raw[j] = w_sum[j];
        end else begin : g_lower
            localparam int D = STAGES - 1 - j;
            logic [W-1:0] r_s_q [0:D-1];

            // Delay line for result chunk j; slot d advances with stage j+1+d.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d < D; d++) begin
                        r_s_q[d] <= '0;
                    end
                end else begin
                    if (w_rdy[j+1]) begin
                        r_s_q[0] <= w_sum[j];
                    end
                    for (int d = 1; d < D; d++) begin
                        if (w_rdy[j+1+d]) begin
                            r_s_q[d] <= r_s_q[d-1];
                        end
                    end
                end
            end

            assign w_s_raw[j] = r_s_q[D-1];
        end
    end

    // Keep the operand sign bits next to the final stage for the overflow/saturation decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_rdy[STAGES-1]) begin
            r_a_msb <= w_a_in[STAGES-1][W-1];
            r_b_msb <= w_b_in[STAGES-1][W-1];
        end
    end

    assign w_s_flat = w_s_raw;
    assign w_ovf    = (r_a_msb == r_b_msb) & (w_s_flat[N-1] != r_a_msb);

`ifdef PIPELINED_ADDER_SAT_EN
    assign w_s_fin = w_ovf ? (r_a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                           : w_s_flat;
`else
    assign w_s_fin = w_s_flat;
`endif

    assign out_valid = w_v[STAGES-1];
    assign s         = w_s_fin;
    assign carry_out = w_cout[STAGES-1];
    assign overflow  = w_ovf;
    assign zero      = out_valid & (w_s_fin == '0);

endmodule
